// File: rtl/simple_risc_pkg.sv
// Shared SimpleRISC constants and writeback-source selection for the RW stage.
package simple_risc_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = $clog2(NUM_REGS);

    localparam logic [REG_AW-1:0] RA_REG = 4'd15;
    localparam logic [XLEN-1:0]   PC_INC = 32'd4;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LD  = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

    // A call always returns through pc+PC_INC, even if the load flag is also set
    function automatic wb_sel_e wb_sel_f(input logic is_call, input logic is_ld);
        wb_sel_e sel;
        if (is_call) begin
            sel = WB_PC;
        end else if (is_ld) begin
            sel = WB_LD;
        end else begin
            sel = WB_ALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rw_stage_reg_file.sv
// NUM_REGS x XLEN register file: one write port, two write-first bypassed read ports.
module reg_file
    import simple_risc_pkg::*;
(
    input  logic              Clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] r_regs [NUM_REGS];

    // Storage array; register 0 is an ordinary writable register
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Same-cycle write is visible on both read ports before it lands in the array
    always_comb begin
        rdata1 = r_regs[raddr1];
        rdata2 = r_regs[raddr2];
        if (we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = r_regs[raddr1];
        end
        if (we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = r_regs[raddr2];
        end
    end

endmodule

// File: rtl/rw_stage.sv
// SimpleRISC register-writeback stage: accept/priority control, writeback mux,
// forwarding record and retired-instruction counter around the register file.
module rw_stage
    import simple_risc_pkg::*;
(
    input  logic              Clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   aluResult,
    input  logic [XLEN-1:0]   ldResult,
    input  logic [REG_AW-1:0] rd,
    input  logic              isWb,
    input  logic              isLd,
    input  logic              isCall,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   retired_count
);

    logic              w_accept;
    logic              w_we;
    wb_sel_e           w_sel;
    logic [XLEN-1:0]   w_value;
    logic [REG_AW-1:0] w_dest;

    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_addr;
    logic [XLEN-1:0]   r_wb_data;
    logic [XLEN-1:0]   r_retired_count;

    assign w_accept = in_valid & ~stall & ~flush & ~reset;
    assign w_we     = w_accept & (isWb | isCall);
    assign w_dest   = isCall ? RA_REG : rd;
    assign w_sel    = wb_sel_f(isCall, isLd);

    // Writeback value mux; pc+PC_INC wraps naturally at 2^XLEN
    always_comb begin
        w_value = aluResult;
        case (w_sel)
            WB_PC:   w_value = pc + PC_INC;
            WB_LD:   w_value = ldResult;
            WB_ALU:  w_value = aluResult;
            default: w_value = aluResult;
        endcase
    end

    reg_file u_reg_file (
        .Clk    (Clk),
        .reset  (reset),
        .we     (w_we),
        .waddr  (w_dest),
        .wdata  (w_value),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Forwarding record: flush drops validity but keeps the last address/data
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= {REG_AW{1'b0}};
            r_wb_data  <= {XLEN{1'b0}};
        end else if (flush) begin
            r_wb_valid <= 1'b0;
        end else if (w_accept) begin
            r_wb_valid <= w_we;
            if (w_we) begin
                r_wb_addr <= w_dest;
                r_wb_data <= w_value;
            end else begin
                r_wb_addr <= r_wb_addr;
                r_wb_data <= r_wb_data;
            end
        end else begin
            r_wb_valid <= r_wb_valid;
        end
    end

    // Retired-instruction counter, including non-writing instructions
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_retired_count <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_retired_count <= r_retired_count + 32'd1;
        end else begin
            r_retired_count <= r_retired_count;
        end
    end

    assign wb_valid      = r_wb_valid;
    assign wb_addr       = r_wb_addr;
    assign wb_data       = r_wb_data;
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_rw_stage.sv
// Self-checking bench for rw_stage: directed scenarios plus a randomized run
// checked against an architectural model of the register file and counters.
module tb_rw_stage;

    logic        Clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [31:0] pc, aluResult, ldResult;
    logic [3:0]  rd, rs1_addr, rs2_addr;
    logic        isWb, isLd, isCall;
    logic [31:0] rs1_data, rs2_data, wb_data, retired_count;
    logic        wb_valid;
    logic [3:0]  wb_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [16];
    logic        m_wbv;
    logic [3:0]  m_wba;
    logic [31:0] m_wbd;
    logic [31:0] m_cnt;

    always #5 Clk = ~Clk;

    rw_stage dut (
        .Clk(Clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .pc(pc), .aluResult(aluResult), .ldResult(ldResult), .rd(rd),
        .isWb(isWb), .isLd(isLd), .isCall(isCall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .retired_count(retired_count)
    );

    // Architectural meaning of the current inputs
    function automatic logic m_write();
        return in_valid && !stall && !flush && !reset && (isWb || isCall);
    endfunction
    function automatic logic [3:0] m_dest();
        return isCall ? 4'd15 : rd;
    endfunction
    function automatic logic [31:0] m_value();
        if (isCall) return pc + 32'd4;
        if (isLd) return ldResult;
        return aluResult;
    endfunction
    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (m_write() && a == m_dest()) return m_value();
        return m_regs[a];
    endfunction

    task automatic set_in(input logic v, input logic st, input logic fl, input logic [31:0] pcv,
                          input logic [31:0] alu, input logic [31:0] ld, input logic [3:0] rdv,
                          input logic wb, input logic l, input logic c);
        in_valid = v; stall = st; flush = fl; pc = pcv; aluResult = alu; ldResult = ld;
        rd = rdv; isWb = wb; isLd = l; isCall = c;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: model next state from current inputs, then land on the next negedge
    task automatic tick();
        logic        we;
        logic [3:0]  d;
        logic [31:0] val;
        we = m_write(); d = m_dest(); val = m_value();
        @(posedge Clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
            m_wbv = 1'b0; m_wba = 4'd0; m_wbd = 32'd0; m_cnt = 32'd0;
        end else if (flush) begin
            m_wbv = 1'b0;
        end else if (stall) begin
            m_wbv = m_wbv;
        end else if (in_valid) begin
            m_cnt = m_cnt + 32'd1;
            m_wbv = we;
            if (we) begin
                m_regs[d] = val; m_wba = d; m_wbd = val;
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); rs1_addr = 4'd0; rs2_addr = 4'd0;
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rs1_addr = a[3:0]; #1;
            checks++;
            if (rs1_data !== 32'd0) begin
                errors++; $display("FAIL reset_reg r%0d got %h want 0", a, rs1_data);
            end
        end
        checks++;
        if (wb_valid !== 1'b0 || retired_count !== 32'd0) begin
            errors++; $display("FAIL reset_state wb_valid %b count %h want 0/0", wb_valid, retired_count);
        end
    endtask

    task automatic test_alu_write();
        set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'h12345678, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        rs1_addr = 4'd3; rs2_addr = 4'd3; #1;
        checks++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            errors++; $display("FAIL bypass_r3 got %h/%h want 12345678", rs1_data, rs2_data);
        end
        tick(); idle(); #1;
        checks++;
        if (rs1_data !== 32'h12345678 || wb_addr !== 4'd3 || wb_valid !== 1'b1 ||
            wb_data !== 32'h12345678 || retired_count !== 32'd1) begin
            errors++; $display("FAIL array_r3 r3 %h wb %b/%0d/%h count %0d want 12345678 1/3/12345678 1",
                               rs1_data, wb_valid, wb_addr, wb_data, retired_count);
        end
    endtask

    task automatic test_ld_call();
        set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'h4, 32'hDEADBEEF, 4'd4, 1'b1, 1'b1, 1'b0);
        tick(); idle(); rs1_addr = 4'd4; #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_r4 got %h want deadbeef", rs1_data);
        end
        set_in(1'b1, 1'b0, 1'b0, 32'h100, 32'h55, 32'h66, 4'd2, 1'b0, 1'b0, 1'b1);
        tick(); idle(); rs1_addr = 4'd15; rs2_addr = 4'd2; #1;
        checks++;
        if (rs1_data !== 32'h104 || rs2_data !== 32'd0 || wb_addr !== 4'd15) begin
            errors++; $display("FAIL call r15 %h r2 %h wb_addr %0d want 104 0 15", rs1_data, rs2_data, wb_addr);
        end
        set_in(1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h55, 32'h66, 4'd2, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (rs1_data !== 32'd0) begin
            errors++; $display("FAIL call_wrap_bypass got %h want 0", rs1_data);
        end
        tick(); idle(); #1;
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || wb_data !== 32'd0 || retired_count !== 32'd4) begin
            errors++; $display("FAIL call_wrap r15 %h r2 %h wb_data %h count %0d want 0 0 0 4",
                               rs1_data, rs2_data, wb_data, retired_count);
        end
    endtask

    task automatic test_stall_flush();
        set_in(1'b1, 1'b1, 1'b0, 32'd0, 32'h1111, 32'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        rs1_addr = 4'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rs1_data !== 32'd0) begin
                errors++; $display("FAIL stall_bypass r5 got %h want 0", rs1_data);
            end
            tick();
            checks++;
            if (rs1_data !== 32'd0 || wb_addr !== 4'd15 || wb_valid !== 1'b1 || retired_count !== 32'd4) begin
                errors++; $display("FAIL stall_hold r5 %h wb %b/%0d count %0d want 0 1/15 4",
                                   rs1_data, wb_valid, wb_addr, retired_count);
            end
        end
        stall = 1'b0;
        tick(); idle(); #1;
        checks++;
        if (rs1_data !== 32'h1111 || retired_count !== 32'd5) begin
            errors++; $display("FAIL stall_release r5 %h count %0d want 1111 5", rs1_data, retired_count);
        end
        set_in(1'b1, 1'b0, 1'b1, 32'd0, 32'h6666, 32'd0, 4'd6, 1'b1, 1'b0, 1'b0);
        rs1_addr = 4'd6; #1;
        checks++;
        if (rs1_data !== 32'd0) begin
            errors++; $display("FAIL flush_bypass r6 got %h want 0", rs1_data);
        end
        tick(); idle(); #1;
        checks++;
        if (rs1_data !== 32'd0 || wb_valid !== 1'b0 || wb_addr !== 4'd5 ||
            wb_data !== 32'h1111 || retired_count !== 32'd5) begin
            errors++; $display("FAIL flush r6 %h wb %b/%0d/%h count %0d want 0 0/5/1111 5",
                               rs1_data, wb_valid, wb_addr, wb_data, retired_count);
        end
    endtask

    task automatic test_store_wrap();
        set_in(1'b1, 1'b0, 1'b0, 32'h200, 32'h77, 32'h88, 4'd9, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        for (int a = 0; a < 16; a++) begin
            rs1_addr = a[3:0]; #1;
            checks++;
            if (rs1_data !== m_regs[a]) begin
                errors++; $display("FAIL store_regs r%0d got %h want %h", a, rs1_data, m_regs[a]);
            end
        end
        checks++;
        if (wb_valid !== 1'b0 || retired_count !== 32'd6) begin
            errors++; $display("FAIL store wb_valid %b count %0d want 0 6", wb_valid, retired_count);
        end
        force dut.r_retired_count = 32'hFFFFFFFF;
        @(posedge Clk); @(negedge Clk);
        release dut.r_retired_count;
        m_cnt = 32'hFFFFFFFF;
        set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd1, 1'b0, 1'b0, 1'b0);
        tick(); idle(); #1;
        checks++;
        if (retired_count !== 32'd0) begin
            errors++; $display("FAIL count_wrap got %h want 0", retired_count);
        end
    endtask

    task automatic test_reset_collision();
        set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'hAAAA, 32'd0, 4'd7, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); reset = 1'b0; idle(); rs1_addr = 4'd7; rs2_addr = 4'd5; #1;
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || wb_valid !== 1'b0 || wb_addr !== 4'd0 ||
            wb_data !== 32'd0 || retired_count !== 32'd0) begin
            errors++; $display("FAIL reset_collision r7 %h r5 %h wb %b/%0d/%h count %0d want all 0",
                               rs1_data, rs2_data, wb_valid, wb_addr, wb_data, retired_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(3) != 0), ($urandom_range(5) == 0), ($urandom_range(9) == 0),
                   $urandom, $urandom, $urandom, 4'($urandom), $urandom_range(1) == 1,
                   $urandom_range(1) == 1, $urandom_range(7) == 0);
            reset = ($urandom_range(99) == 0);
            rs1_addr = 4'($urandom); rs2_addr = ($urandom_range(3) == 0) ? rs1_addr : 4'($urandom);
            #1;
            checks++;
            if (rs1_data !== m_read(rs1_addr) || rs2_data !== m_read(rs2_addr)) begin
                errors++; $display("FAIL rand_read n%0d got %h/%h want %h/%h", n, rs1_data, rs2_data,
                                   m_read(rs1_addr), m_read(rs2_addr));
            end
            tick();
            checks++;
            if (wb_valid !== m_wbv || wb_addr !== m_wba || wb_data !== m_wbd || retired_count !== m_cnt) begin
                errors++; $display("FAIL rand_state n%0d got %b/%0d/%h/%h want %b/%0d/%h/%h", n,
                                   wb_valid, wb_addr, wb_data, retired_count, m_wbv, m_wba, m_wbd, m_cnt);
            end
        end
        reset = 1'b0; idle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_wbv = 1'b0; m_wba = 4'd0; m_wbd = 32'd0; m_cnt = 32'd0;
        reset = 1'b1; idle(); rs1_addr = 4'd0; rs2_addr = 4'd0;
        @(negedge Clk);
        test_reset();
        test_alu_write();
        test_ld_call();
        test_stall_flush();
        test_store_wrap();
        test_reset_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
